// File: rtl/prm_pkg.sv
// prm_pkg: shared definitions for the PRM edge scanner.
//   PRM_JW   - bits per joint field (the JW of the configuration code)
//   N_JOINTS - number of joints packed into one configuration code
//   cfg_t    - packed configuration code {joint2, joint1, joint0}
//   state_t  - edge scanner FSM states
package prm_pkg;

    localparam int PRM_JW   = 5;
    localparam int N_JOINTS = 3;

    typedef struct packed {
        logic [PRM_JW-1:0] joint2;
        logic [PRM_JW-1:0] joint1;
        logic [PRM_JW-1:0] joint0;
    } cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/prm_joint_interp.sv
// prm_joint_interp: rounding linear interpolator for one joint field.
//   start_val - joint value at k = 0
//   end_val   - joint value at k = 2^L
//   k         - sample index, 0 .. 2^L
//   probe_val - round((start*2^L + (end-start)*k) / 2^L)
module prm_joint_interp #(
    parameter int JW = 5,
    parameter int L  = 4
) (
    input  logic [JW-1:0] start_val,
    input  logic [JW-1:0] end_val,
    input  logic [L:0]    k,
    output logic [JW-1:0] probe_val
);

    // One sign bit plus one guard bit over the JW+L magnitude; the true
    // sum stays within [0, (2^JW-1)*2^L + 2^(L-1)], so it never goes negative.
    localparam int W = JW + L + 2;
    localparam logic signed [W-1:0] HALF = W'(2 ** (L - 1));

    logic signed [W-1:0] start_ext;
    logic signed [W-1:0] end_ext;
    logic signed [W-1:0] k_ext;
    logic signed [W-1:0] diff;
    logic signed [W-1:0] acc;

    always_comb begin
        start_ext = $signed({{(W - JW){1'b0}}, start_val});
        end_ext   = $signed({{(W - JW){1'b0}}, end_val});
        k_ext     = $signed({{(W - L - 1){1'b0}}, k});
        diff      = end_ext - start_ext;
        acc       = (start_ext <<< L) + diff * k_ext + HALF;
        probe_val = JW'(acc >>> L);
    end

endmodule

// File: rtl/prm_edge_scan.sv
// prm_edge_scan: walks a PRM edge from start_cfg to end_cfg in 2^LOG2_STEPS+1
// evenly spaced samples, presenting each sample to the obstacle checker and
// stopping at the first collision.
//   CLK, RST               - clock, synchronous active-high reset
//   req_valid/req_ready    - edge request handshake (start_cfg, end_cfg)
//   probe/probe_valid      - current sample code for the obstacle checker
//   chk_mask               - checker hit for the current probe (same cycle)
//   rsp_valid/rsp_ready    - result handshake (rsp_collide, rsp_step)
module prm_edge_scan
    import prm_pkg::*;
#(
    parameter int LOG2_STEPS = 4,
    parameter int JW         = PRM_JW
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [N_JOINTS*JW-1:0] start_cfg,
    input  logic [N_JOINTS*JW-1:0] end_cfg,
    output logic [N_JOINTS*JW-1:0] probe,
    output logic                   probe_valid,
    input  logic                   chk_mask,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_collide,
    output logic [LOG2_STEPS:0]    rsp_step
);

    localparam int CW = N_JOINTS * JW;
    localparam int KW = LOG2_STEPS + 1;
    localparam logic [KW-1:0] K_LAST = KW'(1 << LOG2_STEPS);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] start_q;
    logic [CW-1:0] end_q;
    logic [CW-1:0] interp;
    logic [KW-1:0] k_q;
    logic          collide_q;
    logic [KW-1:0] step_q;
    logic          accept;
    logic          scan_hit;
    logic          scan_end;

    assign accept   = (state_q == ST_IDLE) && req_valid;
    assign scan_hit = (state_q == ST_SCAN) && chk_mask;
    assign scan_end = (state_q == ST_SCAN) && (k_q == K_LAST);

    for (genvar j = 0; j < N_JOINTS; j++) begin : g_joint
        prm_joint_interp #(
            .JW (JW),
            .L  (LOG2_STEPS)
        ) u_interp (
            .start_val (start_q[j*JW +: JW]),
            .end_val   (end_q[j*JW +: JW]),
            .k         (k_q),
            .probe_val (interp[j*JW +: JW])
        );
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid)             state_d = ST_SCAN;
            ST_SCAN: if (chk_mask || scan_end)  state_d = ST_DONE;
            ST_DONE: if (rsp_ready)             state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // Edge codes, sample index and result; a hit takes priority over the
    // final-sample check so a collision at k = 2^L is still reported.
    always_ff @(posedge CLK) begin
        if (RST) begin
            start_q   <= '0;
            end_q     <= '0;
            k_q       <= '0;
            collide_q <= 1'b0;
            step_q    <= '0;
        end else if (accept) begin
            start_q   <= start_cfg;
            end_q     <= end_cfg;
            k_q       <= '0;
            collide_q <= 1'b0;
            step_q    <= '0;
        end else if (scan_hit) begin
            collide_q <= 1'b1;
            step_q    <= k_q;
        end else if (scan_end) begin
            collide_q <= 1'b0;
            step_q    <= '0;
        end else if (state_q == ST_SCAN) begin
            k_q <= k_q + KW'(1);
        end
    end

    // Outputs
    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        probe_valid = (state_q == ST_SCAN);
        probe       = (state_q == ST_SCAN) ? interp : '0;
        rsp_valid   = (state_q == ST_DONE);
        rsp_collide = collide_q;
        rsp_step    = step_q;
    end

endmodule

// File: tb/tb_prm_edge_scan.sv
// tb_prm_edge_scan: self-checking bench for prm_edge_scan (LOG2_STEPS=4, JW=5).
module tb_prm_edge_scan;
    import prm_pkg::*;

    localparam int L  = 4;
    localparam int NS = 1 << L;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [14:0] start_cfg;
    logic [14:0] end_cfg;
    logic [14:0] probe;
    logic        probe_valid;
    logic        chk_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_collide;
    logic [4:0]  rsp_step;

    // Obstacle checker stand-in: one obstacle code, plus a raw override.
    logic        mask_force;
    logic        obs_en;
    logic [14:0] obs_code;
    assign chk_mask = mask_force | (obs_en & probe_valid & (probe == obs_code));

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    prm_edge_scan #(
        .LOG2_STEPS (L),
        .JW         (5)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .start_cfg   (start_cfg),
        .end_cfg     (end_cfg),
        .probe       (probe),
        .probe_valid (probe_valid),
        .chk_mask    (chk_mask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_collide (rsp_collide),
        .rsp_step    (rsp_step)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each joint is the rounded point k/NS of the way along the edge.
    function automatic logic [14:0] model_probe(input logic [14:0] s, input logic [14:0] e, input int k);
        cfg_t cs, ce, cr;
        int   sv[3];
        int   ev[3];
        int   v[3];
        cs = s;
        ce = e;
        sv = '{int'(cs.joint0), int'(cs.joint1), int'(cs.joint2)};
        ev = '{int'(ce.joint0), int'(ce.joint1), int'(ce.joint2)};
        for (int j = 0; j < 3; j++)
            v[j] = (sv[j] * NS + (ev[j] - sv[j]) * k + NS / 2) / NS;
        cr.joint0 = 5'(v[0]);
        cr.joint1 = 5'(v[1]);
        cr.joint2 = 5'(v[2]);
        return cr;
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Runs one edge from IDLE (called at a negedge) through the response handshake.
    task automatic run_edge(input string tag, input logic [14:0] s, input logic [14:0] e,
                            input bit oen, input logic [14:0] ocode,
                            input int hold, input bit keep_req);
        bit exp_hit;
        int exp_k;
        int exp_off;
        int off;
        bit got;
        exp_hit = 1'b0;
        exp_k   = 0;
        for (int k = 0; k <= NS; k++)
            if (!exp_hit && oen && model_probe(s, e, k) == ocode) begin
                exp_hit = 1'b1;
                exp_k   = k;
            end
        exp_off = exp_hit ? exp_k + 2 : NS + 2;

        check({tag, "/req_ready_idle"}, req_ready, 1);
        obs_en    = oen;
        obs_code  = ocode;
        start_cfg = s;
        end_cfg   = e;
        req_valid = 1'b1;
        tick();
        if (!keep_req) req_valid = 1'b0;

        off = 1;
        got = 1'b0;
        while (!got && off <= NS + 4) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                check({tag, "/probe_valid"}, probe_valid, 1);
                check({tag, "/probe"}, probe, model_probe(s, e, off - 1));
                check({tag, "/req_ready_busy"}, req_ready, 0);
                tick();
                off++;
            end
        end
        req_valid = 1'b0;
        check({tag, "/rsp_seen"}, got, 1);
        check({tag, "/rsp_latency"}, off, exp_off);
        check({tag, "/collide"}, rsp_collide, exp_hit);
        check({tag, "/step"}, rsp_step, exp_hit ? exp_k : 0);
        check({tag, "/probe_valid_done"}, probe_valid, 0);

        // Stall the consumer; chk_mask is forced high to show it is ignored.
        mask_force = 1'b1;
        rsp_ready  = 1'b0;
        for (int d = 0; d < hold; d++) begin
            tick();
            check({tag, "/hold_valid"}, rsp_valid, 1);
            check({tag, "/hold_collide"}, rsp_collide, exp_hit);
            check({tag, "/hold_step"}, rsp_step, exp_hit ? exp_k : 0);
            check({tag, "/hold_req_ready"}, req_ready, 0);
        end
        mask_force = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        rsp_ready = 1'b0;
        obs_en    = 1'b0;
        check({tag, "/back_idle_ready"}, req_ready, 1);
        check({tag, "/back_idle_rsp"}, rsp_valid, 0);
        check({tag, "/back_idle_probe"}, probe_valid, 0);
    endtask

    initial begin
        int          seen_rsp;
        logic [14:0] rs, re, rcode;

        RST        = 1'b1;
        req_valid  = 1'b0;
        start_cfg  = '0;
        end_cfg    = '0;
        rsp_ready  = 1'b0;
        mask_force = 1'b0;
        obs_en     = 1'b0;
        obs_code   = '0;
        tick();
        tick();
        check("rst/req_ready", req_ready, 1);
        check("rst/probe_valid", probe_valid, 0);
        check("rst/probe", probe, 0);
        check("rst/rsp_valid", rsp_valid, 0);
        check("rst/rsp_collide", rsp_collide, 0);
        check("rst/rsp_step", rsp_step, 0);
        RST = 1'b0;
        tick();

        // chk_mask in IDLE has no effect
        mask_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_mask/req_ready", req_ready, 1);
            check("idle_mask/probe_valid", probe_valid, 0);
            check("idle_mask/rsp_valid", rsp_valid, 0);
        end
        mask_force = 1'b0;

        run_edge("ascend_clear", 15'h0000, 15'h7FFF, 1'b0, 15'h0000, 0, 1'b0);
        run_edge("ascend_hit8", 15'h0000, 15'h7FFF, 1'b1, 15'h4210, 1, 1'b0);
        run_edge("descend", 15'h7FFF, 15'h0000, 1'b0, 15'h0000, 0, 1'b0);
        run_edge("descend_hit_end", 15'h7FFF, 15'h0000, 1'b1, 15'h0000, 0, 1'b0);
        run_edge("stall5", 15'h0000, 15'h7FFF, 1'b1, 15'h4210, 5, 1'b1);
        run_edge("same_code", 15'h1234, 15'h1234, 1'b0, 15'h0000, 0, 1'b0);
        run_edge("hit_k0", 15'h2A55, 15'h5AA5, 1'b1, 15'h2A55, 2, 1'b0);

        // Reset while sample k=5 is on the probe
        start_cfg = 15'h0000;
        end_cfg   = 15'h7FFF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rst_mid/probe_k5", probe, model_probe(15'h0000, 15'h7FFF, 5));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_mid/probe_valid", probe_valid, 0);
        check("rst_mid/probe", probe, 0);
        check("rst_mid/rsp_valid", rsp_valid, 0);
        check("rst_mid/req_ready", req_ready, 1);
        seen_rsp = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) seen_rsp++;
        end
        check("rst_mid/no_rsp", seen_rsp, 0);
        run_edge("after_rst", 15'h0000, 15'h7FFF, 1'b0, 15'h0000, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            bit oen;
            rs    = 15'($urandom);
            re    = 15'($urandom);
            oen   = 1'($urandom_range(0, 1));
            rcode = model_probe(rs, re, int'($urandom_range(0, NS)));
            run_edge($sformatf("rand%0d", i), rs, re, oen, rcode,
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
